// File: rtl/fpadd_sched_pkg.sv
// fpadd_sched_pkg: shared defaults and the in-flight tracker entry type for fpadd_sched.
// WIDTH falls back to 32 when constants.v has not defined it.
`ifndef WIDTH
`define WIDTH 32
`endif
package fpadd_sched_pkg;
  localparam int NREQ_DEF = 4;
  localparam int TAG_W_DEF = 2;
  localparam int TAG_MAX = 3;
  typedef struct packed {
    logic                v;
    logic [TAG_MAX-1:0]  t;
  } trk_t;
endpackage

// File: rtl/fpadd_sched_rr.sv
// rr_arbiter: round-robin priority search from ptr upward with wrap, plus the next pointer value.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   winner,
  output logic [IW-1:0]   nxt_ptr
);
  logic found;
  int j;
  always_comb begin
    gnt = '0;
    winner = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        winner = IW'(j);
        found = 1'b1;
      end
    end
  end
  assign nxt_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
endmodule

// File: rtl/fpadd_sched.sv
// fpadd_sched: shares one 2-stage fpadd among NREQ requesters with round-robin issue and tagged results.
// Define FPADD_SCHED_BACKPRESSURE_EN to add res_ready and stall the adder while a result is unconsumed.
module fpadd_sched
  import fpadd_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*`WIDTH-1:0] a_in,
  input  logic [NREQ*`WIDTH-1:0] b_in,
  input  logic [NREQ-1:0]        op_in,
`ifdef FPADD_SCHED_BACKPRESSURE_EN
  input  logic                   res_ready,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [`WIDTH-1:0]      fp_a,
  output logic [`WIDTH-1:0]      fp_b,
  output logic                   fp_op,
  output logic                   fp_ce,
  input  logic [`WIDTH-1:0]      fp_z,
  output logic                   res_valid,
  output logic [`WIDTH-1:0]      res_data,
  output logic [TAG_W-1:0]       res_tag
);
  trk_t r_s1, r_s2;
  logic [TAG_W-1:0] r_ptr, w_win, w_nxt;
  logic w_en, w_issue;
`ifdef FPADD_SCHED_BACKPRESSURE_EN
  assign fp_ce = rst | ~(r_s2.v & ~res_ready);
`else
  assign fp_ce = 1'b1;
`endif
  assign w_en = fp_ce & ~rst;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req),
    .ptr(r_ptr),
    .en(w_en),
    .gnt(gnt),
    .winner(w_win),
    .nxt_ptr(w_nxt)
  );
  assign w_issue = |(req & gnt);
  always_comb begin
    fp_a = '0;
    fp_b = '0;
    fp_op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        fp_a = a_in[i*`WIDTH +: `WIDTH];
        fp_b = b_in[i*`WIDTH +: `WIDTH];
        fp_op = op_in[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (fp_ce) begin
      r_ptr <= w_issue ? w_nxt : r_ptr;
      r_s1 <= trk_t'{v: w_issue, t: TAG_MAX'(w_win)};
      r_s2 <= r_s1;
    end
  end
  assign res_valid = r_s2.v & ~rst;
  assign res_tag = TAG_W'(r_s2.t);
  assign res_data = fp_z;
endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: directed vector table plus hand-written contention, reset, fairness and stall sequences.
`ifndef WIDTH
`define WIDTH 32
`endif
module tb_fpadd_sched;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, op_in, gnt;
  logic [N*W-1:0] a_in, b_in;
  logic [W-1:0] fp_a, fp_b, fp_z, res_data;
  logic fp_op, fp_ce, res_valid;
  logic [1:0] res_tag;
`ifdef FPADD_SCHED_BACKPRESSURE_EN
  logic res_ready;
`endif
  logic [W-1:0] m1 = '0, m2 = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fpadd_sched dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
`ifdef FPADD_SCHED_BACKPRESSURE_EN
    .res_ready(res_ready),
`endif
    .gnt(gnt), .fp_a(fp_a), .fp_b(fp_b), .fp_op(fp_op), .fp_ce(fp_ce), .fp_z(fp_z),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag)
  );
  function automatic real f2r(logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction
  // Behavioural fpadd: two ce-gated register stages, no reset
  always @(posedge clk) begin
    if (fp_ce) begin
      m1 <= r2f(fp_op ? f2r(fp_a) - f2r(fp_b) : f2r(fp_a) + f2r(fp_b));
      m2 <= m1;
    end
  end
  assign fp_z = m2;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic setop(input int r, input logic [31:0] a, input logic [31:0] b, input logic op);
    a_in[r*W +: W] = a;
    b_in[r*W +: W] = b;
    op_in[r] = op;
  endtask
  typedef struct {
    int r;
    logic [31:0] a;
    logic [31:0] b;
    logic op;
    logic [31:0] z;
  } vec_t;
  vec_t tv[4];
  logic [31:0] cz[4];
  initial begin
    int w;
    tv[0] = '{1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    tv[1] = '{3, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    tv[2] = '{0, 32'h40A00000, 32'h3F000000, 1'b0, 32'h40B00000};
    tv[3] = '{2, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    cz = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    rst = 1'b1;
    req = '1;
    a_in = '0;
    b_in = '0;
    op_in = '0;
`ifdef FPADD_SCHED_BACKPRESSURE_EN
    res_ready = 1'b1;
`endif
    setop(0, 32'h3F800000, 32'h3F800000, 1'b0);
    setop(1, 32'h3F800000, 32'h40000000, 1'b0);
    setop(2, 32'h3F800000, 32'h40400000, 1'b0);
    setop(3, 32'h3F800000, 32'h40800000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_ce", 32'(fp_ce), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("cont_gnt", 32'(gnt), 32'(1 << (c % 4)));
      chk("cont_ce", 32'(fp_ce), 32'h1);
      if (c >= 2) begin
        chk("cont_valid", 32'(res_valid), 32'h1);
        chk("cont_tag", 32'(res_tag), 32'((c - 2) % 4));
        chk("cont_data", res_data, cz[(c - 2) % 4]);
      end else chk("cont_novalid", 32'(res_valid), 32'h0);
      @(negedge clk);
    end
    req = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      setop(tv[i].r, tv[i].a, tv[i].b, tv[i].op);
      req = N'(1 << tv[i].r);
      #1;
      chk("vec_gnt", 32'(gnt), 32'(1 << tv[i].r));
      chk("vec_fpa", fp_a, tv[i].a);
      chk("vec_fpop", 32'(fp_op), 32'(tv[i].op));
      @(negedge clk);
      req = '0;
      #1;
      chk("vec_early", 32'(res_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("vec_valid", 32'(res_valid), 32'h1);
      chk("vec_data", res_data, tv[i].z);
      chk("vec_tag", 32'(res_tag), 32'(tv[i].r));
      @(negedge clk);
      #1;
      chk("vec_once", 32'(res_valid), 32'h0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    setop(0, 32'h3F800000, 32'h3F800000, 1'b0);
    setop(2, 32'h3F800000, 32'h40400000, 1'b0);
    req = 4'b0101;
    #1;
    chk("mid_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 4'b0100;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_gnt2", 32'(gnt), 32'h4);
    chk("mid_flush0", 32'(res_valid), 32'h0);
    @(negedge clk);
    req = '0;
    #1;
    chk("mid_flush1", 32'(res_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("mid_valid2", 32'(res_valid), 32'h1);
    chk("mid_tag2", 32'(res_tag), 32'h2);
    chk("mid_data2", res_data, 32'h40800000);
    @(negedge clk);
    req = 4'b0001;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      req[2] = 1'b1;
      w = 0;
      #1;
      while (!gnt[2] && w < 3) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("fair_wait", 32'(w < 2), 32'h1);
      @(negedge clk);
      req[2] = 1'b0;
      #1;
      chk("fair_gnt0", 32'(gnt), 32'h1);
    end
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
`ifdef FPADD_SCHED_BACKPRESSURE_EN
    setop(1, 32'h3F800000, 32'h40000000, 1'b0);
    setop(3, 32'h40400000, 32'h3F800000, 1'b1);
    req = 4'b0010;
    #1;
    chk("bp_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    req = 4'b1000;
    #1;
    chk("bp_gnt3", 32'(gnt), 32'h8);
    @(negedge clk);
    req = 4'b0001;
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_valid", 32'(res_valid), 32'h1);
      chk("bp_tag", 32'(res_tag), 32'h1);
      chk("bp_data", res_data, 32'h40400000);
      chk("bp_gnt", 32'(gnt), 32'h0);
      chk("bp_ce", 32'(fp_ce), 32'h0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    req = '0;
    #1;
    chk("bp_release_ce", 32'(fp_ce), 32'h1);
    chk("bp_release_tag", 32'(res_tag), 32'h1);
    @(negedge clk);
    #1;
    chk("bp_next_valid", 32'(res_valid), 32'h1);
    chk("bp_next_tag", 32'(res_tag), 32'h3);
    chk("bp_next_data", res_data, 32'h40000000);
    repeat (3) @(negedge clk);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
